mem_copy_engine: RTL
====================

// Module: mem_copy_engine
// PURPOSE
//   Command-driven initiator for the single-port 8-bit data memory (async read, sync write).
//   Accepts one copy or fill command and sequences memory accesses byte by byte.
//   Reports an 8-bit additive checksum of the bytes written.
//   Sits between the control FSM/CPU and the data memory port, which it owns while busy.
// PARAMETERS
//   AW  8       memory address width (memory depth 2**AW)
//   DW  8       memory data width
//   LW  AW+1    length field width; holds 0..2**AW inclusive
// PORTS
//   clk        in   1   clock; all state changes on posedge
//   rst        in   1   synchronous, active-high reset
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   engine idle, can accept a command
//   cmd_mode   in   1   0 = copy src->dst, 1 = fill dst with cmd_fill
//   cmd_src    in   AW  copy source start address (ignored for fill)
//   cmd_dst    in   AW  destination start address
//   cmd_len    in   LW  byte count, 0..256
//   cmd_fill   in   DW  fill byte (ignored for copy)
//   mem_addr   out  AW  memory address
//   mem_wr     out  1   memory write enable
//   mem_wdata  out  DW  memory write data
//   mem_rdata  in   DW  memory read data, combinational from mem_addr
//   busy       out  1   high in every non-IDLE state
//   done       out  1   one-cycle pulse at command completion
//   sum        out  DW  mod-2**DW sum of all bytes written by the last command
// BEHAVIOUR
//   Reset: state=IDLE; cmd_ready=1; busy=0; done=0; sum=0; mem_addr=0; mem_wr=0; mem_wdata=0.
//   Handshake: cmd_ready = (state==IDLE) && !rst. A command is accepted on a posedge with cmd_valid && cmd_ready.
//   Commands presented while busy are not accepted. Fields are registered at acceptance.
//   On accept: src_ptr, dst_ptr, rem=cmd_len, data_reg=cmd_fill, and mode are loaded; sum is cleared.
//   States:
//     IDLE  -> DONE if cmd_len==0; else WRITE if fill; else READ.
//     READ  : mem_addr=src_ptr, mem_wr=0. At posedge, data_reg<=mem_rdata. -> WRITE.
//     WRITE : mem_addr=dst_ptr, mem_wr=1, mem_wdata=data_reg. At posedge: sum+=data_reg,
//             dst_ptr++, src_ptr++ (copy only), rem--. -> DONE if rem==1; else READ (copy) or WRITE (fill).
//     DONE  : done=1 for exactly this cycle; mem_wr=0. -> IDLE.
//   IDLE/DONE drive mem_addr=0 and mem_wdata=0.
//   Latency: copy N>0 = 2N cycles of access, with done high in cycle 2N+1 after accept.
//            Fill N>0 gives done in cycle N+1. N=0 gives done in cycle 1 with no memory writes.
//   Pointers wrap mod 2**AW (0xFF+1 -> 0x00); N=256 touches every address exactly once.
//   Overlap: strict ascending byte-by-byte copy. If dst is in (src, src+N), already-written bytes
//            are re-read; this is the defined result, with no memmove semantics.
//   sum holds its value after done until the next accept.
//   Reset mid-operation aborts the command. mem_wr is gated: mem_wr = (state==WRITE) && !rst,
//            so no write occurs in a reset cycle. No done pulse follows an abort.
//   Memory is not restored after an abort; bytes already written stay written.
// TESTING
//   1. Copy src=0x10 dst=0x80 len=4, mem[0x10..0x13]=01,02,03,04 -> mem[0x80..0x83]=01..04;
//      done in cycle 9 after accept; sum=0x0A.
//   2. Fill dst=0xFE len=3 fill=0xA5 -> mem[0xFE],[0xFF],[0x00]=A5 (wrap); done in cycle 4; sum=0xEF.
//   3. len=0 copy -> no mem_wr pulses; done in cycle 1; sum=0; cmd_ready back high in cycle 2.
//   4. Overlap copy src=0x20 dst=0x21 len=3, mem[0x20]=0x55 -> mem[0x21..0x23]=0x55.
//   5. Assert rst during the 2nd WRITE of a len=8 fill -> mem_wr=0 that cycle; only 1 byte written;
//      busy=0 and sum=0 next cycle; no done pulse.
//   6. Hold cmd_valid with a new command during busy -> it is ignored until done;
//      it is accepted in the first IDLE cycle after DONE.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Bundle of command handshake, memory port and status signals for mem_copy_engine.
// The engine connects through the slave modport. The master modport is for whatever
// issues commands and owns the memory array (a CPU/control FSM, or a testbench).
interface mem_copy_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = AW + 1
);
    // Command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_fill;

    // Memory port: read is combinational from mem_addr, write is synchronous
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;
    logic          done;
    logic [DW-1:0] sum;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        output cmd_ready,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata,
        output busy, done, sum
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        input  cmd_ready,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata,
        input  busy, done, sum
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial copy/fill engine for a single-port 8-bit memory (async read, sync write).
// A copy alternates READ (latch the source byte) and WRITE (store it at the destination).
// A fill stays in WRITE and stores the registered fill byte every cycle.
// The engine keeps a mod-2**DW running sum of the bytes it writes. Reset aborts a command
// immediately, and the write strobe is gated by reset so that nothing is written in the reset cycle.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_copy_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q,   state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [LW-1:0] rem_q,     rem_d;
    logic [DW-1:0] data_q,    data_d;
    logic [DW-1:0] sum_q,     sum_d;
    logic          mode_q,    mode_d;

    // State and datapath registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            sum_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            sum_q     <= sum_d;
            mode_q    <= mode_d;
        end
    end

    // Next-state logic: load the command in IDLE, then step pointers and the byte count per write
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        data_d    = data_q;
        sum_d     = sum_q;
        mode_d    = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    src_ptr_d = bus.cmd_src;
                    dst_ptr_d = bus.cmd_dst;
                    rem_d     = bus.cmd_len;
                    data_d    = bus.cmd_fill;
                    mode_d    = bus.cmd_mode;
                    sum_d     = '0;
                    if (bus.cmd_len == '0) begin
                        state_d = DONE;
                    end else if (bus.cmd_mode) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                data_d  = bus.mem_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                sum_d     = sum_q + data_q;
                dst_ptr_d = dst_ptr_q + AW'(1);
                if (!mode_q) begin
                    src_ptr_d = src_ptr_q + AW'(1);
                end
                rem_d = rem_q - LW'(1);
                if (rem_q == LW'(1)) begin
                    state_d = DONE;
                end else if (mode_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port and status outputs decoded from the current state; writes are gated by reset
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.cmd_ready = (state_q == IDLE) && !rst;
        bus.sum       = sum_q;
        unique case (state_q)
            IDLE: begin
                bus.mem_addr = '0;
            end
            READ: begin
                bus.mem_addr = src_ptr_q;
            end
            WRITE: begin
                bus.mem_addr  = dst_ptr_q;
                bus.mem_wr    = !rst;
                bus.mem_wdata = data_q;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.done = 1'b0;
            end
        endcase
    end

endmodule
